// File: rtl/eeprom_ctrl.sv
// Command sequencer for a 93C46-style SPI master: turns byte read/write requests into EWEN/WRITE/READ.
// Optional build macro EEPROM_EWEN_CACHE_EN skips EWEN once it has succeeded since reset or err.
module eeprom_ctrl #(
    parameter int unsigned TIMEOUT = 1500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic [6:0] usr_addr,
    input  logic [7:0] usr_wdata,
    output logic       busy,
    output logic [7:0] usr_rdata,
    output logic       usr_rdata_vld,
    output logic       usr_done,
    output logic       err,
    output logic       spi_start,
    output logic [1:0] spi_mode,
    output logic [6:0] spi_addr,
    output logic [7:0] spi_wdata,
    input  logic       spi_rdy,
    input  logic [7:0] spi_rdata,
    input  logic       spi_rdata_vld
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] MODE_EWEN  = 2'b00;
    localparam logic [1:0] MODE_WRITE = 2'b01;
    localparam logic [1:0] MODE_READ  = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StEwenReq,
        StEwenWait,
        StWrReq,
        StWrWait,
        StRdReq,
        StRdWait
    } state_e;

    state_e        state;
    logic [CW-1:0] to_cnt;
    logic          seen_busy;
    logic [6:0]    addr_q;
    logic [7:0]    wdata_q;
    logic [7:0]    rd_buf;
`ifdef EEPROM_EWEN_CACHE_EN
    logic          ewen_done;
`endif

    logic in_req;
    logic in_wait;
    logic timed_out;
    logic cmd_done;

    always_comb begin
        in_req    = (state == StEwenReq) || (state == StWrReq) || (state == StRdReq);
        in_wait   = (state == StEwenWait) || (state == StWrWait) || (state == StRdWait);
        timed_out = (in_req || in_wait) && (to_cnt == TO_LAST);
        // rdy lags start by a cycle, so completion needs a busy phase seen first
        cmd_done  = in_wait && spi_rdy && seen_busy;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= StIdle;
            to_cnt        <= '0;
            seen_busy     <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rd_buf        <= '0;
            busy          <= 1'b0;
            usr_rdata     <= '0;
            usr_rdata_vld <= 1'b0;
            usr_done      <= 1'b0;
            err           <= 1'b0;
            spi_start     <= 1'b0;
            spi_mode      <= '0;
            spi_addr      <= '0;
            spi_wdata     <= '0;
`ifdef EEPROM_EWEN_CACHE_EN
            ewen_done     <= 1'b0;
`endif
        end else begin
            spi_start     <= 1'b0;
            usr_done      <= 1'b0;
            usr_rdata_vld <= 1'b0;
            err           <= 1'b0;

            if (in_req || in_wait) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (timed_out) begin
                state     <= StIdle;
                busy      <= 1'b0;
                err       <= 1'b1;
                seen_busy <= 1'b0;
`ifdef EEPROM_EWEN_CACHE_EN
                ewen_done <= 1'b0;
`endif
            end else begin
                unique case (state)
                    StIdle: begin
                        if (wr_req) begin
                            addr_q  <= usr_addr;
                            wdata_q <= usr_wdata;
                            busy    <= 1'b1;
                            to_cnt  <= '0;
`ifdef EEPROM_EWEN_CACHE_EN
                            state   <= ewen_done ? StWrReq : StEwenReq;
`else
                            state   <= StEwenReq;
`endif
                        end else if (rd_req) begin
                            addr_q <= usr_addr;
                            busy   <= 1'b1;
                            to_cnt <= '0;
                            state  <= StRdReq;
                        end
                    end

                    StEwenReq: begin
                        if (spi_rdy) begin
                            spi_start <= 1'b1;
                            spi_mode  <= MODE_EWEN;
                            spi_addr  <= '0;
                            spi_wdata <= '0;
                            seen_busy <= 1'b0;
                            state     <= StEwenWait;
                        end
                    end

                    StEwenWait: begin
                        if (!spi_rdy) begin
                            seen_busy <= 1'b1;
                        end
                        if (cmd_done) begin
                            seen_busy <= 1'b0;
                            to_cnt    <= '0;
                            state     <= StWrReq;
`ifdef EEPROM_EWEN_CACHE_EN
                            ewen_done <= 1'b1;
`endif
                        end
                    end

                    StWrReq: begin
                        if (spi_rdy) begin
                            spi_start <= 1'b1;
                            spi_mode  <= MODE_WRITE;
                            spi_addr  <= addr_q;
                            spi_wdata <= wdata_q;
                            seen_busy <= 1'b0;
                            state     <= StWrWait;
                        end
                    end

                    StWrWait: begin
                        if (!spi_rdy) begin
                            seen_busy <= 1'b1;
                        end
                        if (cmd_done) begin
                            seen_busy <= 1'b0;
                            busy      <= 1'b0;
                            usr_done  <= 1'b1;
                            state     <= StIdle;
                        end
                    end

                    StRdReq: begin
                        if (spi_rdy) begin
                            spi_start <= 1'b1;
                            spi_mode  <= MODE_READ;
                            spi_addr  <= addr_q;
                            spi_wdata <= '0;
                            seen_busy <= 1'b0;
                            state     <= StRdWait;
                        end
                    end

                    StRdWait: begin
                        if (!spi_rdy) begin
                            seen_busy <= 1'b1;
                        end
                        if (spi_rdata_vld) begin
                            rd_buf <= spi_rdata;
                        end
                        if (cmd_done) begin
                            // data may arrive in the same cycle as the rdy rise
                            usr_rdata     <= spi_rdata_vld ? spi_rdata : rd_buf;
                            usr_rdata_vld <= 1'b1;
                            usr_done      <= 1'b1;
                            seen_busy     <= 1'b0;
                            busy          <= 1'b0;
                            state         <= StIdle;
                        end
                    end

                    default: begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eeprom_ctrl.sv
// Bench for eeprom_ctrl: directed and random requests against an SPI/EEPROM device model.
// Build with EEPROM_EWEN_CACHE_EN defined for both bench and RTL to check the EWEN cache variant.
`timescale 1ns/1ps
module tb_eeprom_ctrl;

    localparam int unsigned TO = 50;
`ifdef EEPROM_EWEN_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] mode;
        logic [6:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_req;
    logic       rd_req;
    logic [6:0] usr_addr;
    logic [7:0] usr_wdata;
    logic       busy;
    logic [7:0] usr_rdata;
    logic       usr_rdata_vld;
    logic       usr_done;
    logic       err;
    logic       spi_start;
    logic [1:0] spi_mode;
    logic [6:0] spi_addr;
    logic [7:0] spi_wdata;
    logic       spi_rdy;
    logic [7:0] spi_rdata;
    logic       spi_rdata_vld;

    always #5 clk = ~clk;

    eeprom_ctrl #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .usr_addr     (usr_addr),
        .usr_wdata    (usr_wdata),
        .busy         (busy),
        .usr_rdata    (usr_rdata),
        .usr_rdata_vld(usr_rdata_vld),
        .usr_done     (usr_done),
        .err          (err),
        .spi_start    (spi_start),
        .spi_mode     (spi_mode),
        .spi_addr     (spi_addr),
        .spi_wdata    (spi_wdata),
        .spi_rdy      (spi_rdy),
        .spi_rdata    (spi_rdata),
        .spi_rdata_vld(spi_rdata_vld)
    );

    int n_cmp;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Device model: rdy drops one cycle after start, rises after a random latency
    cmd_t            log_q[$];
    int              cyc;
    int              hold_until;
    bit              hang;
    bit              m_active, m_lag, m_stuck, m_wen, m_vld_sent, m_early;
    int              m_cnt;
    cmd_t            m_cmd;
    logic [7:0]      dev_mem [int];

    always @(negedge clk) begin
        cyc++;
        spi_rdata_vld = 1'b0;
        spi_rdata     = 8'($urandom);
        if (rst_n !== 1'b1) begin
            m_active = 1'b0;
            m_lag    = 1'b0;
            m_stuck  = 1'b0;
            m_wen    = 1'b0;
            spi_rdy  = 1'b1;
        end else if (spi_start === 1'b1) begin
            check("start_only_when_rdy", spi_rdy, 1);
            m_cmd      = cmd_t'{spi_mode, spi_addr, spi_wdata};
            log_q.push_back(m_cmd);
            m_active   = 1'b1;
            m_lag      = 1'b1;
            m_vld_sent = 1'b0;
            m_early    = 1'($urandom_range(0, 1));
        end else if (m_active) begin
            if (busy === 1'b1) begin
                check("mode_stable", spi_mode, m_cmd.mode);
                check("addr_stable", spi_addr, m_cmd.addr);
                check("wdata_stable", spi_wdata, m_cmd.wdata);
            end
            if (m_lag) begin
                m_lag   = 1'b0;
                spi_rdy = 1'b0;
                if (hang) m_stuck = 1'b1;
                else m_cnt = $urandom_range(1, 5);
            end else if (m_stuck) begin
                if (!hang) begin
                    m_stuck  = 1'b0;
                    m_active = 1'b0;
                    spi_rdy  = 1'b1;
                end
            end else begin
                m_cnt--;
                if (m_cmd.mode == 2'b10 && !m_vld_sent && (m_cnt == 0 || (m_cnt == 1 && m_early))) begin
                    spi_rdata_vld = 1'b1;
                    spi_rdata     = dev_mem.exists(int'(m_cmd.addr)) ? dev_mem[int'(m_cmd.addr)] : 8'h00;
                    m_vld_sent    = 1'b1;
                end
                if (m_cnt == 0) begin
                    m_active = 1'b0;
                    spi_rdy  = 1'b1;
                    if (m_cmd.mode == 2'b00) m_wen = 1'b1;
                    else if (m_cmd.mode == 2'b01 && m_wen) dev_mem[int'(m_cmd.addr)] = m_cmd.wdata;
                end
            end
        end else begin
            spi_rdy = (cyc >= hold_until);
        end
    end

    int done_cnt, err_cnt, vld_cnt;

    always @(negedge clk) begin
        if (usr_done === 1'b1) done_cnt++;
        if (err === 1'b1) begin
            err_cnt++;
            check("err_without_done", usr_done, 0);
        end
        if (usr_rdata_vld === 1'b1) begin
            vld_cnt++;
            check("vld_with_done", usr_done, 1);
            check("vld_with_busy_low", busy, 0);
        end
    end

    // Reference: what the user should see, from request-level rules only
    bit         ref_ewen;
    logic [7:0] ref_mem [int];
    logic [7:0] ref_rdata;
    int         exp_done, exp_err, exp_vld;

    function automatic logic [7:0] ref_get(input logic [6:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    task automatic do_op(input bit is_wr, input bit both, input bit pulse_rd, input bit hang_it,
                         input logic [6:0] a, input logic [7:0] d);
        cmd_t exp_q[$];
        cmd_t got;
        int   n0;
        int   k;
        bit   fin;
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("idle_before_op", busy, 0);
        if (is_wr || both) begin
            if (!CACHE || !ref_ewen) exp_q.push_back(cmd_t'{2'b00, 7'h00, 8'h00});
            exp_q.push_back(cmd_t'{2'b01, a, d});
        end else begin
            exp_q.push_back(cmd_t'{2'b10, a, 8'h00});
        end
        if (hang_it) begin
            while (exp_q.size() > 1) void'(exp_q.pop_back());
        end
        hang = hang_it;
        if (!hang_it && $urandom_range(0, 3) == 0) begin
            hold_until = cyc + 2 + int'($urandom_range(0, 3));
            @(negedge clk);
        end
        n0        = log_q.size();
        usr_addr  = a;
        usr_wdata = d;
        wr_req    = is_wr || both;
        rd_req    = !is_wr || both;
        @(negedge clk);
        wr_req    = 1'b0;
        rd_req    = 1'b0;
        usr_addr  = 7'($urandom);
        usr_wdata = 8'($urandom);
        check("busy_after_accept", busy, 1);
        check("no_done_after_accept", usr_done, 0);
        k   = 1;
        fin = 1'b0;
        while (!fin && k < 200) begin
            rd_req = pulse_rd && (k == 2);
            @(negedge clk);
            k++;
            if (usr_done === 1'b1 || err === 1'b1) fin = 1'b1;
            else check("busy_held", busy, 1);
        end
        rd_req = 1'b0;
        check("op_finished", fin, 1);
        if (fin) begin
            check("busy_low_at_end", busy, 0);
            check("start_count", log_q.size() - n0, exp_q.size());
            for (int i = 0; i < exp_q.size() && n0 + i < log_q.size(); i++) begin
                got = log_q[n0 + i];
                check("start_mode", got.mode, exp_q[i].mode);
                check("start_addr", got.addr, exp_q[i].addr);
                if (exp_q[i].mode != 2'b10) check("start_wdata", got.wdata, exp_q[i].wdata);
            end
            if (hang_it) begin
                check("err_pulse", err, 1);
                check("timeout_cycles", k - 1, TO);
                check("rdata_kept", usr_rdata, ref_rdata);
                exp_err++;
                ref_ewen = 1'b0;
            end else begin
                check("done_pulse", usr_done, 1);
                check("no_err", err, 0);
                exp_done++;
                if (is_wr || both) begin
                    ref_mem[int'(a)] = d;
                    ref_ewen = 1'b1;
                    check("no_vld_on_write", usr_rdata_vld, 0);
                end else begin
                    ref_rdata = ref_get(a);
                    check("rdata_vld", usr_rdata_vld, 1);
                    check("rdata", usr_rdata, ref_rdata);
                    exp_vld++;
                end
            end
        end
        if (hang_it) begin
            hang = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_start"}, spi_start, 0);
        check({tag, "_done"}, usr_done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_vld"}, usr_rdata_vld, 0);
        check({tag, "_rdata"}, usr_rdata, 0);
        check({tag, "_mode"}, spi_mode, 0);
        check({tag, "_addr"}, spi_addr, 0);
        check({tag, "_wdata"}, spi_wdata, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n0;
        int   k;
        int   nexp;
        logic [6:0] a;
        logic [7:0] d;
        rst_n     = 1'b0;
        wr_req    = 1'b0;
        rd_req    = 1'b0;
        usr_addr  = '0;
        usr_wdata = '0;
        ref_rdata = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_op(1'b1, 1'b0, 1'b0, 1'b0, 7'h15, 8'hA5);
        do_op(1'b0, 1'b0, 1'b0, 1'b0, 7'h15, 8'h00);
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 7'h22, 8'h3C);
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 7'h23, 8'hC3);
        do_op(1'b0, 1'b0, 1'b0, 1'b0, 7'h22, 8'h00);

        do_op(1'b1, 1'b0, 1'b0, 1'b1, 7'h40, 8'h11);
        do_op(1'b0, 1'b0, 1'b0, 1'b1, 7'h23, 8'h00);
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 7'h40, 8'h5A);
        do_op(1'b0, 1'b0, 1'b0, 1'b0, 7'h40, 8'h00);

        do_op(1'b1, 1'b1, 1'b1, 1'b0, 7'h31, 8'h77);
        do_op(1'b0, 1'b0, 1'b0, 1'b0, 7'h31, 8'h00);

        // write cut off by reset while its WRITE command is in flight
        nexp      = (CACHE && ref_ewen) ? 1 : 2;
        n0        = log_q.size();
        usr_addr  = 7'h15;
        usr_wdata = 8'h99;
        wr_req    = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        k = 0;
        while (log_q.size() < n0 + nexp && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("write_start_before_reset", log_q.size() - n0, nexp);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("midreset");
        rst_n    = 1'b1;
        ref_ewen = 1'b0;
        ref_rdata = 8'h00;
        @(negedge clk);
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 7'h15, 8'h6E);
        do_op(1'b0, 1'b0, 1'b0, 1'b0, 7'h15, 8'h00);

        for (int i = 0; i < 40; i++) begin
            a = 7'($urandom_range(0, 7));
            d = 8'($urandom);
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 3) == 0), 1'b0, a, d);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("done_one_cycle", usr_done, 0);
            end
        end

        repeat (3) @(negedge clk);
        check("total_done", done_cnt, exp_done);
        check("total_err", err_cnt, exp_err);
        check("total_vld", vld_cnt, exp_vld);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/eeprom_ctrl.md
# eeprom_ctrl

Command sequencer directly upstream of the 93C46-style SPI master. It accepts single-byte read and write requests from the user side. It issues the required EWEN / WRITE / READ command sequence to the SPI master through its start/mode/rdy handshake, and returns read data, completion and error status to the user.

## Interface
- TIMEOUT, 1500000: maximum clk cycles spent waiting on one SPI command (15 ms at 100 MHz) before aborting.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset, synchronous, active-low.
- wr_req  in  1  user write request, sampled when busy=0.
- rd_req  in  1  user read request, sampled when busy=0.
- usr_addr  in  7  EEPROM address, captured on acceptance.
- usr_wdata  in  8  write data, captured on acceptance.
- busy  out  1  request in progress.
- usr_rdata  out  8  read data, valid with usr_rdata_vld.
- usr_rdata_vld  out  1  one-cycle pulse, read completed.
- usr_done  out  1  one-cycle pulse, read or write completed successfully.
- err  out  1  one-cycle pulse, timeout abort.
- spi_start  out  1  one-cycle command strobe to the SPI master.
- spi_mode  out  2  00 EWEN, 01 WRITE, 10 READ.
- spi_addr  out  7  command address.
- spi_wdata  out  8  command write data.
- spi_rdy  in  1  SPI master idle.
- spi_rdata  in  8  SPI read data.
- spi_rdata_vld  in  1  SPI read data valid pulse.

## Operation
- States: IDLE, EWEN_REQ, EWEN_WAIT, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT.
- IDLE, wr_req=1: capture addr/data, set busy, go to EWEN_REQ (or WR_REQ, see Configuration).
- IDLE, rd_req=1 (wr_req=0): capture addr, set busy, go to RD_REQ.
- Both requests high: write wins and the read is dropped. Requests while busy=1 are ignored; there is no queueing.
- X_REQ: wait for spi_rdy=1, then pulse spi_start for one cycle with spi_mode/spi_addr/spi_wdata valid, and go to X_WAIT.
- spi_mode, spi_addr and spi_wdata stay stable from the start pulse until X_WAIT exits.
- For EWEN, spi_addr and spi_wdata are driven 0.
- X_WAIT uses an internal seen_busy flag. It sets on spi_rdy=0, and the command is complete on spi_rdy=1 with seen_busy=1. This guards against the one-cycle lag of rdy after start.
- Transitions on completion:
  - EWEN_WAIT goes to WR_REQ.
  - WR_WAIT goes to IDLE and pulses usr_done.
  - RD_WAIT goes to IDLE and pulses usr_done and usr_rdata_vld.
- spi_rdata is captured whenever spi_rdata_vld=1 in RD_WAIT. It may coincide with the rdy rise.
- Timeout counter: cleared on entry to each REQ state and increments in REQ and WAIT states. When it reaches TIMEOUT-1 the block pulses err, goes to IDLE and clears busy. No usr_done is issued and usr_rdata is unchanged.
- Counter width is ceil(log2(TIMEOUT)).

## Timing
- Reset values are 0 for every output and for all internal state; the FSM goes to IDLE.
- Request accepted on edge N: busy=1 from N+1. spi_start is at the earliest N+2 (REQ state registers the strobe).
- Completion detected on edge M: usr_done, usr_rdata_vld and busy=0 all appear at M+1. A new request may be accepted at M+1.
- spi_start is never asserted while spi_rdy=0.
- Reset mid-operation: next edge returns to IDLE, outputs are 0, and no pulse is emitted. The SPI master is reset by the same rst_n.

## Configuration
- EEPROM_EWEN_CACHE_EN defined: an ewen_done flag is set after the first successful EWEN completion and cleared only by reset or err.
  - Writes with ewen_done=1 go IDLE to WR_REQ directly.
- Not defined: every write issues EWEN first. There is no flag register.

## Test plan
- Macro off, write addr 0x15 data 0xA5, SPI model: two starts, first mode=00, second mode=01/addr=0x15/wdata=0xA5. usr_done pulses once, err=0, busy high from accept+1 to done.
- Read addr 0x15, model returns 0xA5: one start with mode=10/addr=0x15. usr_rdata=0xA5 and usr_rdata_vld pulses 1 cycle together with busy falling.
- Macro on, two back-to-back writes: EWEN issued only before the first. The second write has exactly one start, mode=01.
- TIMEOUT=50, model holds spi_rdy=0 after start forever: err pulses after 50 cycles in REQ+WAIT, busy=0, no usr_done. The next request is accepted.
- wr_req=rd_req=1 in the same cycle, then rd_req pulsed while busy: write performed only, no READ start observed.
- rst_n low for 1 cycle during WR_WAIT: all outputs 0 next cycle, no usr_done or err pulse. With the macro on, the next write re-issues EWEN.
